// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register slave.
package spi_reg_pkg;

  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned DUMMY_CYCLES = 8;
  localparam int unsigned FRAME_W      = ADDR_W + DUMMY_CYCLES + DATA_W;

  // Address bit that marks a frame as read-only.
  localparam int unsigned RoBit = 7;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bit counter only needs to reach (longest field - 1).
  localparam int unsigned CNT_W = $clog2(max3(ADDR_W, DUMMY_CYCLES, DATA_W));

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StDummy,
    StData,
    StDone
  } state_e;

endpackage

// File: rtl/spi_reg_slave_if.sv
// Register-file handshake between the SPI engine (master) and the register file (slave).
interface spi_reg_slave_if;
  import spi_reg_pkg::*;

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_rvalid;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata, reg_rvalid
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata, reg_rvalid
  );

endinterface

// File: rtl/spi_reg_slave_sync_edge.sv
// Two-flop synchronizer with registered rise/fall detection (pin to edge pulse: 3 clocks).
module sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q, rise_q, fall_q;

  // Synchronize, keep one delayed copy, register the edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= ResetVal;
      s2_q   <= ResetVal;
      s3_q   <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave frame engine: address, dummy and data fields in; previous address and read data out.
module spi_reg_slave import spi_reg_pkg::*; (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   spi_clk,
  input  logic                   spi_mosi,
  input  logic                   spi_cs_n,
  output logic                   spi_miso,
  spi_reg_slave_if.master        reg_bus,
  output logic                   busy
);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_s1_q, mosi_s2_q;

  sync_edge #(.ResetVal(1'b0)) u_sync_sclk (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .d_i    (spi_clk),
    .q_o    (sclk_level_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // CS_n resets high so a reset never fakes a frame start.
  sync_edge #(.ResetVal(1'b1)) u_sync_cs (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .d_i    (spi_cs_n),
    .q_o    (cs_level),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Plain two-flop synchronizer for MOSI.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-2:0]  rx_q;       // all received bits of a field except the last
  logic [FRAME_W-1:0] tx_q;       // tx_q[MSB] is the bit on MISO
  logic [DATA_W-1:0]  rd_q;
  logic [DATA_W-1:0]  rd_next;
  logic [ADDR_W-1:0]  prev_addr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q, re_q;

  // Read data arriving in the same cycle as the dummy-to-data step still counts.
  always_comb begin
    rd_next = rd_q;
    if (reg_bus.reg_rvalid) rd_next = reg_bus.reg_rdata;
  end

  // Frame FSM with counter, shifters and registered strobes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_q        <= '0;
      prev_addr_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      if (cs_rise) begin
        // End of frame, or abort if not DONE: nothing more is written or committed.
        state_q <= StIdle;
        cnt_q   <= '0;
        tx_q    <= '0;
        rd_q    <= '0;
      end else begin
        if ((state_q == StAddr || state_q == StDummy) && reg_bus.reg_rvalid) begin
          rd_q <= reg_bus.reg_rdata;
        end
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q <= StAddr;
              tx_q    <= {prev_addr_q, {(FRAME_W - ADDR_W){1'b0}}};
              rd_q    <= '0;
              // An SCLK rise seen together with CS fall is bit 0.
              if (sclk_rise) begin
                rx_q  <= {{(DATA_W - 2){1'b0}}, mosi_s2_q};
                cnt_q <= CNT_W'(1);
              end else begin
                rx_q  <= '0;
                cnt_q <= '0;
              end
            end
          end
          StAddr: begin
            if (sclk_fall) tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
            if (sclk_rise) begin
              rx_q <= {rx_q[DATA_W-3:0], mosi_s2_q};
              if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                addr_q  <= {rx_q[ADDR_W-2:0], mosi_s2_q};
                re_q    <= 1'b1;
                cnt_q   <= '0;
                state_q <= StDummy;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          StDummy: begin
            if (sclk_fall) tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
            if (sclk_rise) begin
              if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                // Keep the dummy bit on MISO; read data comes out from the next fall.
                tx_q    <= {tx_q[FRAME_W-1], rd_next, {(FRAME_W - 1 - DATA_W){1'b0}}};
                cnt_q   <= '0;
                state_q <= StData;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          StData: begin
            if (sclk_fall) tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
            if (sclk_rise) begin
              rx_q <= {rx_q[DATA_W-3:0], mosi_s2_q};
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                if (!addr_q[RoBit]) begin
                  wdata_q <= {rx_q, mosi_s2_q};
                  we_q    <= 1'b1;
                end
                prev_addr_q <= addr_q;
                cnt_q       <= '0;
                state_q     <= StDone;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          StDone: begin
            // Extra SCLK edges are ignored until CS rises.
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign spi_miso          = tx_q[FRAME_W-1];
  assign busy              = ~cs_level;
  assign reg_bus.reg_addr  = addr_q;
  assign reg_bus.reg_wdata = wdata_q;
  assign reg_bus.reg_we    = we_q;
  assign reg_bus.reg_re    = re_q;

endmodule
